// File: rtl/mem_pkg.sv
// Shared types and default sizing for the two-requester memory arbiter.
package mem_pkg;

   localparam int unsigned ADDR_W_DEF    = 10;
   localparam int unsigned DATA_W_DEF    = 8;
   localparam int unsigned MAX_BURST_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_burst_sel.sv
// Grant selection: round-robin between two requesters with a bounded burst
// length for the current owner.
module rr_burst_sel
   import mem_pkg::*;
#(
   parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1
);

   localparam int unsigned      CNT_W   = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

   arb_state_t       state, state_nxt;
   logic             last, last_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             at_max, same_owner;

   assign at_max = (cnt == CNT_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         last  <= 1'b1;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      gnt0       = 1'b0;
      gnt1       = 1'b0;
      state_nxt  = IDLE;
      last_nxt   = last;
      cnt_nxt    = '0;
      same_owner = 1'b0;

      // The owner keeps the grant until its burst is exhausted and the other side waits.
      unique case (state)
         OWN0: begin
            if (req0 && !(at_max && req1)) gnt0 = 1'b1;
            else                           gnt1 = req1;
         end
         OWN1: begin
            if (req1 && !(at_max && req0)) gnt1 = 1'b1;
            else                           gnt0 = req0;
         end
         default: begin
            if (req0 && req1) begin
               gnt0 = last;
               gnt1 = !last;
            end else begin
               gnt0 = req0;
               gnt1 = req1;
            end
         end
      endcase

      if (reset) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end

      same_owner = (gnt0 && (state == OWN0)) || (gnt1 && (state == OWN1));

      if (gnt0) begin
         state_nxt = OWN0;
         last_nxt  = 1'b0;
      end else if (gnt1) begin
         state_nxt = OWN1;
         last_nxt  = 1'b1;
      end

      if (gnt0 || gnt1) begin
         if (!same_owner) cnt_nxt = CNT_W'(1);
         else if (at_max) cnt_nxt = cnt;
         else             cnt_nxt = cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory with synchronous
// write and registered read; read data returns two cycles after acceptance.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W    = ADDR_W_DEF,
   parameter int unsigned DATA_W    = DATA_W_DEF,
   parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              mem_write_enable,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   logic              accept;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              rd_pend;
   logic              rd_owner;

   rr_burst_sel #(
      .MAX_BURST (MAX_BURST)
   ) u_sel (
      .clk   (clk),
      .reset (reset),
      .req0  (req0),
      .req1  (req1),
      .gnt0  (gnt0),
      .gnt1  (gnt1)
   );

   assign accept    = gnt0 | gnt1;
   assign sel_we    = gnt1 ? we1    : we0;
   assign sel_addr  = gnt1 ? addr1  : addr0;
   assign sel_wdata = gnt1 ? wdata1 : wdata0;

   // The memory registers its read output, so rdata is a passthrough aligned with stage two.
   assign rdata = mem_read_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_write_enable <= 1'b0;
         mem_addr         <= '0;
         mem_write_data   <= '0;
         rd_pend          <= 1'b0;
         rd_owner         <= 1'b0;
         rvalid0          <= 1'b0;
         rvalid1          <= 1'b0;
      end else begin
         mem_write_enable <= accept & sel_we;
         if (accept) begin
            mem_addr       <= sel_addr;
            mem_write_data <= sel_wdata;
         end
         rd_pend  <= accept & ~sel_we;
         rd_owner <= gnt1;
         rvalid0  <= rd_pend & ~rd_owner;
         rvalid1  <= rd_pend &  rd_owner;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus hand-written reset and
// burst-saturation sequences, with a second instance at MAX_BURST=1.
module tb_mem_arbiter;

   logic       clk;
   logic       reset;
   logic       req0, req1, we0, we1;
   logic [9:0] addr0, addr1;
   logic [7:0] wdata0, wdata1;
   logic       gnt0, gnt1, rvalid0, rvalid1;
   logic [7:0] rdata;
   logic       mem_write_enable;
   logic [9:0] mem_addr;
   logic [7:0] mem_write_data;
   logic [7:0] mem_read_data;

   logic       b_req0, b_req1;
   logic       b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mwe;
   logic [7:0] b_rdata, b_mwd, b_mrd;
   logic [9:0] b_maddr;

   int errors = 0;
   int checks = 0;

   logic [7:0] mem [0:1023];

   mem_arbiter #(
      .ADDR_W    (10),
      .DATA_W    (8),
      .MAX_BURST (4)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .req0             (req0),
      .req1             (req1),
      .we0              (we0),
      .we1              (we1),
      .addr0            (addr0),
      .addr1            (addr1),
      .wdata0           (wdata0),
      .wdata1           (wdata1),
      .gnt0             (gnt0),
      .gnt1             (gnt1),
      .rvalid0          (rvalid0),
      .rvalid1          (rvalid1),
      .rdata            (rdata),
      .mem_write_enable (mem_write_enable),
      .mem_addr         (mem_addr),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data)
   );

   mem_arbiter #(
      .ADDR_W    (10),
      .DATA_W    (8),
      .MAX_BURST (1)
   ) dut1 (
      .clk              (clk),
      .reset            (reset),
      .req0             (b_req0),
      .req1             (b_req1),
      .we0              (1'b0),
      .we1              (1'b0),
      .addr0            (10'd6),
      .addr1            (10'd7),
      .wdata0           (8'h00),
      .wdata1           (8'h00),
      .gnt0             (b_gnt0),
      .gnt1             (b_gnt1),
      .rvalid0          (b_rvalid0),
      .rvalid1          (b_rvalid1),
      .rdata            (b_rdata),
      .mem_write_enable (b_mwe),
      .mem_addr         (b_maddr),
      .mem_write_data   (b_mwd),
      .mem_read_data    (b_mrd)
   );

   // Single-port memory: synchronous write, registered read.
   always @(posedge clk) begin
      if (mem_write_enable) mem[mem_addr] <= mem_write_data;
      mem_read_data <= mem[mem_addr];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       r0, w0;
      logic [9:0] a0;
      logic [7:0] d0;
      logic       r1, w1;
      logic [9:0] a1;
      logic [7:0] d1;
      logic       g0, g1, mwe, v0, v1;
      logic [7:0] rd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r0, input logic w0, input logic [9:0] a0, input logic [7:0] d0,
                      input logic r1, input logic w1, input logic [9:0] a1, input logic [7:0] d1,
                      input logic g0, input logic g1, input logic mwe,
                      input logic v0, input logic v1, input logic [7:0] rd);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.v0 = v0; v.v1 = v1; v.rd = rd;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r0, input logic w0, input logic [9:0] a0, input logic [7:0] d0,
                        input logic r1, input logic w1, input logic [9:0] a1, input logic [7:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
   endtask

   initial begin
      reset = 1'b1;
      b_req0 = 1'b0; b_req1 = 1'b0; b_mrd = 8'h3C;
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      //    r0 w0 a0    d0     r1 w1 a1    d1     g0 g1 mwe v0 v1 rd
      add(1, 1, 2,    8'h22, 0, 0, 0,    0,     1, 0, 0,  0, 0, 0);     // c0
      add(0, 0, 0,    0,     1, 1, 3,    8'h33, 0, 1, 1,  0, 0, 0);     // c1
      add(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 1,  0, 0, 0);     // c2
      add(1, 0, 2,    0,     1, 0, 3,    0,     1, 0, 0,  0, 0, 0);     // c3 contention
      add(1, 0, 2,    0,     1, 0, 3,    0,     1, 0, 0,  0, 0, 0);
      add(1, 0, 2,    0,     1, 0, 3,    0,     1, 0, 0,  1, 0, 8'h22);
      add(1, 0, 2,    0,     1, 0, 3,    0,     1, 0, 0,  1, 0, 8'h22);
      add(1, 0, 2,    0,     1, 0, 3,    0,     0, 1, 0,  1, 0, 8'h22); // c7 burst handover
      add(1, 0, 2,    0,     1, 0, 3,    0,     0, 1, 0,  1, 0, 8'h22);
      add(1, 0, 2,    0,     1, 0, 3,    0,     0, 1, 0,  0, 1, 8'h33);
      add(1, 0, 2,    0,     1, 0, 3,    0,     0, 1, 0,  0, 1, 8'h33);
      add(1, 0, 2,    0,     1, 0, 3,    0,     1, 0, 0,  0, 1, 8'h33);
      add(1, 0, 2,    0,     1, 0, 3,    0,     1, 0, 0,  0, 1, 8'h33);
      add(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 0,  1, 0, 8'h22); // c13
      add(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 0,  1, 0, 8'h22);
      add(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 0,  0, 0, 0);
      add(1, 0, 2,    0,     0, 0, 0,    0,     1, 0, 0,  0, 0, 0);     // c16 req0 drops after 2
      add(1, 0, 2,    0,     1, 0, 3,    0,     1, 0, 0,  0, 0, 0);
      add(0, 0, 0,    0,     1, 0, 3,    0,     0, 1, 0,  1, 0, 8'h22);
      add(1, 0, 2,    0,     1, 0, 3,    0,     0, 1, 0,  1, 0, 8'h22);
      add(1, 0, 2,    0,     1, 0, 3,    0,     0, 1, 0,  0, 1, 8'h33);
      add(1, 0, 2,    0,     1, 0, 3,    0,     0, 1, 0,  0, 1, 8'h33);
      add(1, 0, 2,    0,     1, 0, 3,    0,     1, 0, 0,  0, 1, 8'h33); // c22 count restarted at 1
      add(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 0,  0, 1, 8'h33);
      add(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 0,  1, 0, 8'h22);
      add(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 0,  0, 0, 0);
      add(1, 1, 1,    8'h04, 0, 0, 0,    0,     1, 0, 0,  0, 0, 0);     // c26 write then read
      add(1, 0, 1,    0,     0, 0, 0,    0,     1, 0, 1,  0, 0, 0);
      add(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 0,  0, 0, 0);
      add(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 0,  1, 0, 8'h04);
      add(0, 0, 0,    0,     1, 1, 1023, 8'hFF, 0, 1, 0,  0, 0, 0);     // c30 top address
      add(1, 1, 0,    8'h5A, 0, 0, 0,    0,     1, 0, 1,  0, 0, 0);
      add(1, 0, 1023, 0,     0, 0, 0,    0,     1, 0, 1,  0, 0, 0);
      add(1, 0, 0,    0,     0, 0, 0,    0,     1, 0, 0,  0, 0, 0);
      add(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 0,  1, 0, 8'hFF);
      add(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 0,  1, 0, 8'h5A);
      add(0, 0, 0,    0,     0, 0, 0,    0,     0, 0, 0,  0, 0, 0);

      @(negedge clk);
      @(negedge clk);
      #1;
      check("reset gnt0", 32'(gnt0), 0);
      check("reset gnt1", 32'(gnt1), 0);
      check("reset rvalid", 32'({rvalid0, rvalid1}), 0);
      check("reset mwe", 32'(mem_write_enable), 0);
      check("reset mem_addr", 32'(mem_addr), 0);
      check("reset mem_wdata", 32'(mem_write_data), 0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].d0,
               vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].d1);
         #1;
         check($sformatf("v%0d gnt0", i), 32'(gnt0), 32'(vecs[i].g0));
         check($sformatf("v%0d gnt1", i), 32'(gnt1), 32'(vecs[i].g1));
         check($sformatf("v%0d mwe", i), 32'(mem_write_enable), 32'(vecs[i].mwe));
         check($sformatf("v%0d rvalid0", i), 32'(rvalid0), 32'(vecs[i].v0));
         check($sformatf("v%0d rvalid1", i), 32'(rvalid1), 32'(vecs[i].v1));
         if (vecs[i].v0 || vecs[i].v1)
            check($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].rd));
      end

      // Sole requester keeps the grant; count saturates so contention hands over at once.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 1, 0, 3, 0);
         #1;
         check($sformatf("solo%0d gnt1", k), 32'(gnt1), 1);
         check($sformatf("solo%0d gnt0", k), 32'(gnt0), 0);
      end
      @(negedge clk);
      drive(1, 0, 2, 0, 1, 0, 3, 0);
      #1;
      check("sat handover gnt0", 32'(gnt0), 1);
      check("sat handover gnt1", 32'(gnt1), 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset one cycle after a read is accepted, with a write pending.
      @(negedge clk);
      drive(1, 0, 2, 0, 0, 0, 0, 0);
      #1;
      check("rst read gnt0", 32'(gnt0), 1);
      @(negedge clk);
      drive(0, 0, 0, 0, 1, 1, 5, 8'h77);
      reset = 1'b1;
      #1;
      check("rst gnt1 blocked", 32'(gnt1), 0);
      check("rst gnt0", 32'(gnt0), 0);
      @(negedge clk);
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      check("post rst mwe", 32'(mem_write_enable), 0);
      check("post rst rvalid0", 32'(rvalid0), 0);
      check("post rst mem_addr", 32'(mem_addr), 0);
      @(negedge clk);
      #1;
      check("post rst rvalid", 32'({rvalid0, rvalid1}), 0);
      check("post rst mwe2", 32'(mem_write_enable), 0);
      @(negedge clk);
      drive(1, 0, 2, 0, 1, 0, 3, 0);
      #1;
      check("post rst first gnt0", 32'(gnt0), 1);
      check("post rst first gnt1", 32'(gnt1), 0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // MAX_BURST=1 instance: strict alternation under contention.
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         b_req0 = 1'b1; b_req1 = 1'b1;
         #1;
         check($sformatf("mb1 alt%0d gnt0", k), 32'(b_gnt0), 32'((k % 2) == 0));
         check($sformatf("mb1 alt%0d gnt1", k), 32'(b_gnt1), 32'((k % 2) == 1));
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         b_req0 = 1'b0; b_req1 = 1'b1;
         #1;
         check($sformatf("mb1 solo%0d gnt1", k), 32'(b_gnt1), 1);
      end
      check("mb1 rvalid1", 32'(b_rvalid1), 1);
      check("mb1 rvalid0", 32'(b_rvalid0), 0);
      check("mb1 rdata", 32'(b_rdata), 32'h3C);
      check("mb1 mem_addr", 32'(b_maddr), 7);
      check("mb1 mwe", 32'(b_mwe), 0);
      check("mb1 mem_wdata", 32'(b_mwd), 0);
      @(negedge clk);
      b_req1 = 1'b0;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
